// File: rtl/skew_sequencer_if.sv
// Interface for skew_sequencer: upstream vector handshake plus the skew-chain drive bus.
//
// Handshake: a vector is transferred on a rising clk edge where in_valid and
// in_ready are both high. in_valid may rise or fall at any time. in_ready is a
// function of the sequencer state only, never of in_valid. skew_en is a
// qualifier, not a handshake: the chain advances on every edge where it is high.
interface skew_sequencer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int N          = 4
);
    logic                    in_valid;
    logic                    in_ready;
    logic [N*DATA_WIDTH-1:0] in_data;
    logic                    skew_en;
    logic [N*DATA_WIDTH-1:0] skew_din;
    logic [N-1:0]            lane_valid;

    // Upstream source / observer of the skew drive.
    modport master (
        output in_valid, in_data,
        input  in_ready, skew_en, skew_din, lane_valid
    );

    // Sequencer side.
    modport slave (
        input  in_valid, in_data,
        output in_ready, skew_en, skew_din, lane_valid
    );
endinterface

// File: rtl/skew_sequencer.sv
// skew_sequencer: feeds a frame of N-lane vectors into an N-deep skew chain,
// then flushes the chain with N-1 zero beats and pulses done.
// Optional macro SKEW_SEQ_STALL_CNT_EN adds a 16-bit stall_cnt output that
// counts FEED cycles without a valid upstream vector.
module skew_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int N          = 4,
    parameter int LEN_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             abort,
    skew_sequencer_if.slave  bus,
    output logic             busy,
    output logic             done
`ifdef SKEW_SEQ_STALL_CNT_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

    // Tag register has N-1 entries; keep one dummy bit when N == 1.
    localparam int TW  = (N > 1) ? N - 1 : 1;
    // Drain counter runs 0 .. N-2.
    localparam int DCW = (N > 2) ? $clog2(N - 1) : 1;
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'((N > 1) ? N - 2 : 0);

    state_t           state;
    state_t           state_next;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] beat_cnt;
    logic [DCW-1:0]   drain_cnt;
    logic [TW-1:0]    tag;
    logic             is_feed;
    logic             abort_take;

    assign abort_take = abort && (state == FEED || state == DRAIN);

    // Next-state decode and all combinational outputs.
    always_comb begin
        state_next   = state;
        is_feed      = 1'b0;
        bus.in_ready = 1'b0;
        bus.skew_en  = 1'b0;
        bus.skew_din = '0;
        busy         = (state != IDLE);
        done         = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (frame_len != '0) ? FEED : DONE;
                end
            end
            FEED: begin
                is_feed      = 1'b1;
                bus.in_ready = 1'b1;
                bus.skew_din = bus.in_data;
                bus.skew_en  = bus.in_valid;
                // beat_cnt holds beats already taken, so the last one arrives at len_q-1
                if (bus.in_valid && beat_cnt == len_q - LEN_W'(1)) begin
                    state_next = (N == 1) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                bus.skew_en = 1'b1;
                if (drain_cnt == DRAIN_LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Cancel takes priority over a last beat or the final drain beat.
        if (abort_take) begin
            state_next = IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Frame length latch, beat counter and drain counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q     <= '0;
            beat_cnt  <= '0;
            drain_cnt <= '0;
        end else if (abort_take) begin
            beat_cnt  <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && frame_len != '0) begin
                        len_q     <= frame_len;
                        beat_cnt  <= '0;
                        drain_cnt <= '0;
                    end
                end
                FEED:    if (bus.in_valid) beat_cnt <= beat_cnt + LEN_W'(1);
                DRAIN:   drain_cnt <= drain_cnt + DCW'(1);
                default: ;
            endcase
        end
    end

    // Tag shift register: marks which chain stages hold a real vector element.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag <= '0;
        end else if (abort_take) begin
            tag <= '0;
        end else if (bus.skew_en) begin
            tag[0] <= is_feed;
            for (int k = 1; k < TW; k++) begin
                tag[k] <= tag[k-1];
            end
        end
    end

    // Lane y is live when the element entered y advances ago was a real beat.
    always_comb begin
        bus.lane_valid    = '0;
        bus.lane_valid[0] = bus.skew_en & is_feed;
        for (int y = 1; y < N; y++) begin
            bus.lane_valid[y] = bus.skew_en & tag[y-1];
        end
    end

`ifdef SKEW_SEQ_STALL_CNT_EN
    // Saturating count of FEED cycles with no upstream vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (state == IDLE && start) begin
            stall_cnt <= '0;
        end else if (state == FEED && !bus.in_valid && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: doc/skew_sequencer.md
SKEW_SEQUENCER -- requirements
Module: skew_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: bit width of one lane element.
REQ-002 SHALL have parameter N, default 4: number of lanes, which is also the depth of the skew chain being driven; legal N >= 1.
REQ-003 SHALL have parameter LEN_W, default 8: width of the frame-length field.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port start, input, 1 bit: frame start request, honoured only in IDLE.
REQ-007 SHALL have port frame_len, input, LEN_W bits: number of vectors in the frame, sampled on an accepted start.
REQ-008 SHALL have port abort, input, 1 bit: synchronous frame cancel.
REQ-009 SHALL have port in_valid, input, 1 bit: the upstream vector is valid.
REQ-010 SHALL have port in_ready, output, 1 bit: the sequencer accepts the vector.
REQ-011 SHALL have port in_data, input, N*DATA_WIDTH bits: flattened vector, with lane y in bits [y*DATA_WIDTH +: DATA_WIDTH].
REQ-012 SHALL have port skew_en, output, 1 bit: advance enable to the skew chain.
REQ-013 SHALL have port skew_din, output, N*DATA_WIDTH bits: data to the skew chain, same lane packing as in_data.
REQ-014 SHALL have port lane_valid, output, N bits: per-lane flag that the skewed output currently carries a real vector element.
REQ-015 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-016 SHALL have port done, output, 1 bit: one-cycle pulse marking frame completion.

Function
REQ-017 SHALL implement the states IDLE, FEED, DRAIN and DONE.
REQ-018 IDLE: in_ready=0 and skew_en=0. start with frame_len != 0 SHALL latch frame_len, clear the beat counter and move to FEED. start with frame_len == 0 SHALL move to DONE.
REQ-019 FEED: in_ready=1, skew_din=in_data, and skew_en = in_valid & in_ready, so the chain advances only on an accepted beat.
REQ-020 FEED SHALL count accepted beats; the beat that reaches the latched frame_len SHALL move the FSM to DRAIN, or to DONE when N == 1.
REQ-021 DRAIN: in_ready=0, skew_en=1 every cycle and skew_din=0, for exactly N-1 cycles, then move to DONE.
REQ-022 DONE: done=1 for one cycle, then move to IDLE; skew_en=0 in DONE.
REQ-023 SHALL keep an N-1 entry tag shift register that advances only when skew_en=1.
- On each advance, tag[0] <= (state==FEED) and tag[k] <= tag[k-1].
REQ-024 lane_valid[0] SHALL equal skew_en & (state==FEED); lane_valid[y] for y >= 1 SHALL equal skew_en & tag[y-1].
REQ-025 Latency: element y of an accepted vector SHALL appear with lane_valid[y]=1 on the y-th skew_en cycle after its acceptance cycle.
REQ-026 abort in FEED or DRAIN SHALL move to IDLE on the next edge, clear all tags and the beat counter, and SHALL NOT pulse done.
- abort wins over a simultaneous last beat or drain end.
- abort in IDLE or DONE SHALL have no effect.
REQ-027 start outside IDLE SHALL be ignored; frame_len SHALL be ignored except on an accepted start.
REQ-028 The beat counter SHALL be LEN_W bits wide; frame_len = 2^LEN_W-1 SHALL complete without wrap.

Reset
REQ-029 rst_n low SHALL immediately force IDLE and clear the tags, the beat counter and the latched length, independent of clk.
REQ-030 Reset values: in_ready=0, skew_en=0, skew_din=0, lane_valid=0, busy=0, done=0.
REQ-031 Reset asserted mid-frame SHALL discard the frame with no done pulse.

Configuration
REQ-032 Macro SKEW_SEQ_STALL_CNT_EN defined: the block SHALL add output stall_cnt, 16 bits, cleared on accepted start and on reset.
- stall_cnt increments on every FEED cycle with in_valid=0 and saturates at 0xFFFF.
REQ-033 Macro SKEW_SEQ_STALL_CNT_EN undefined: the port and its counter SHALL be absent; all other behaviour is identical.

Verification
REQ-034 N=4, frame_len=3, in_valid held high -> 3 FEED cycles with skew_en=1, 3 DRAIN cycles with skew_din=0, done pulse on cycle 7 after start, busy low after it.
REQ-035 N=4, frame_len=2, in_valid toggling 1,0,1 -> skew_en=1,0,1; lane_valid[3] high on exactly 2 drain-phase cycles; stall_cnt=1 when the macro is defined.
REQ-036 start with frame_len=0 -> done on the next cycle, skew_en never high.
REQ-037 abort asserted on the second beat of a 5-vector frame -> IDLE on the next cycle, lane_valid=0, no done pulse; a following start runs normally.
REQ-038 rst_n dropped mid-DRAIN, asynchronously -> outputs reach reset values before the next clk edge; start ignored while busy is checked with a mid-FEED start pulse.
